// File: rtl/bp_cce_mem_cmd_gate_pkg.sv
// Shared constants for the CCE memory command gate and its header buffer.
package bp_cce_mem_cmd_gate_pkg;

    localparam int unsigned occ_width_lp = 2;

    localparam logic [occ_width_lp-1:0] occ_empty_lp = 2'd0;
    localparam logic [occ_width_lp-1:0] occ_one_lp   = 2'd1;
    localparam logic [occ_width_lp-1:0] occ_full_lp  = 2'd2;

endpackage

// File: rtl/bp_cce_mem_cmd_buffer.sv
// Two-entry FIFO for memory command headers with head/tail registers and
// same-cycle enqueue/dequeue support at every occupancy.
module bp_cce_mem_cmd_buffer
    import bp_cce_mem_cmd_gate_pkg::*;
#(
    parameter int unsigned header_width_p = 128
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] data_i,
    input  logic                      enq_i,
    input  logic                      deq_i,
    output logic [header_width_p-1:0] head_o,
    output logic                      v_o,
    output logic                      full_o
);

    logic [header_width_p-1:0] head_r, head_n;
    logic [header_width_p-1:0] tail_r, tail_n;
    logic [occ_width_lp-1:0]   occ_r, occ_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= occ_empty_lp;
        end else begin
            head_r <= head_n;
            tail_r <= tail_n;
            occ_r  <= occ_n;
        end
    end

    // Head always holds the oldest entry; tail is only meaningful at occupancy 2.
    always_comb begin
        head_n = head_r;
        tail_n = tail_r;
        occ_n  = occ_r;
        unique case (occ_r)
            occ_empty_lp: begin
                if (enq_i) begin
                    head_n = data_i;
                    occ_n  = occ_one_lp;
                end
            end
            occ_one_lp: begin
                unique case ({enq_i, deq_i})
                    2'b11: head_n = data_i;
                    2'b10: begin
                        tail_n = data_i;
                        occ_n  = occ_full_lp;
                    end
                    2'b01: occ_n = occ_empty_lp;
                    default: ;
                endcase
            end
            occ_full_lp: begin
                if (deq_i) begin
                    head_n = tail_r;
                    if (enq_i) begin
                        tail_n = data_i;
                    end else begin
                        occ_n = occ_one_lp;
                    end
                end
            end
            default: occ_n = occ_empty_lp;
        endcase
    end

    assign head_o = head_r;
    assign v_o    = (occ_r != occ_empty_lp);
    assign full_o = (occ_r == occ_full_lp);

endmodule

// File: rtl/bp_cce_mem_cmd_gate.sv
// Output-side gate for CCE memory commands: buffers headers toward the network
// and tracks memory credits that throttle the CCE.
module bp_cce_mem_cmd_gate #(
    parameter  int unsigned mem_noc_max_credits_p = 8,
    parameter  int unsigned header_width_p        = 128,
    localparam int unsigned lg_credits_lp         = $clog2(mem_noc_max_credits_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] mem_cmd_header_i,
    input  logic                      mem_cmd_header_v_i,
    output logic                      mem_cmd_header_ready_and_o,
    output logic [header_width_p-1:0] mem_cmd_header_o,
    output logic                      mem_cmd_header_v_o,
    input  logic                      mem_cmd_header_ready_and_i,
    input  logic                      mem_credit_return_i,
    output logic                      mem_credits_empty_o,
    output logic                      mem_credits_full_o,
    output logic [lg_credits_lp-1:0]  mem_credit_count_o,
    output logic                      credit_error_o
);

    localparam logic [lg_credits_lp-1:0] max_count_lp = lg_credits_lp'(mem_noc_max_credits_p);

    logic [lg_credits_lp-1:0] count_r, count_n;
    logic                     error_r, error_n;
    logic                     buf_full;
    logic                     accept;
    logic                     send;

    assign accept = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;
    assign send   = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;

    bp_cce_mem_cmd_buffer #(
        .header_width_p(header_width_p)
    ) buffer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (mem_cmd_header_i),
        .enq_i     (accept),
        .deq_i     (send),
        .head_o    (mem_cmd_header_o),
        .v_o       (mem_cmd_header_v_o),
        .full_o    (buf_full)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= max_count_lp;
            error_r <= 1'b0;
        end else begin
            count_r <= count_n;
            error_r <= error_n;
        end
    end

    // A return at max credits is a protocol error; the count saturates instead.
    always_comb begin
        count_n = count_r;
        error_n = error_r;
        unique case ({accept, mem_credit_return_i})
            2'b10: count_n = count_r - lg_credits_lp'(1);
            2'b01: begin
                if (count_r == max_count_lp) begin
                    error_n = 1'b1;
                end else begin
                    count_n = count_r + lg_credits_lp'(1);
                end
            end
            default: ;
        endcase
    end

    assign mem_cmd_header_ready_and_o = ~buf_full & (count_r != '0);
    assign mem_credits_empty_o        = (count_r == '0);
    assign mem_credits_full_o         = (count_r == max_count_lp);
    assign mem_credit_count_o         = count_r;
    assign credit_error_o             = error_r;

endmodule

// File: tb/tb_bp_cce_mem_cmd_gate.sv
// Self-checking bench: two gates (8 and 2 credits) share stimulus and are
// compared each cycle against a queue/integer model, plus literal checkpoints.
module tb_bp_cce_mem_cmd_gate;

    localparam int unsigned HW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] hdr;
    logic          v_in, net_rdy, ret;

    logic          rdy8, v8, empty8, full8, err8;
    logic [HW-1:0] hdr8;
    logic [3:0]    cnt8;
    logic          rdy2, v2, empty2, full2, err2;
    logic [HW-1:0] hdr2;
    logic [1:0]    cnt2;

    int n_vec = 0;
    int n_mis = 0;

    logic [HW-1:0] mq [2][$];
    int            mcr [2];
    bit            merr [2];

    always #5 clk = ~clk;

    bp_cce_mem_cmd_gate #(.mem_noc_max_credits_p(8), .header_width_p(HW)) dut8 (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_header_i(hdr), .mem_cmd_header_v_i(v_in),
        .mem_cmd_header_ready_and_o(rdy8), .mem_cmd_header_o(hdr8),
        .mem_cmd_header_v_o(v8), .mem_cmd_header_ready_and_i(net_rdy),
        .mem_credit_return_i(ret), .mem_credits_empty_o(empty8),
        .mem_credits_full_o(full8), .mem_credit_count_o(cnt8),
        .credit_error_o(err8)
    );

    bp_cce_mem_cmd_gate #(.mem_noc_max_credits_p(2), .header_width_p(HW)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_header_i(hdr), .mem_cmd_header_v_i(v_in),
        .mem_cmd_header_ready_and_o(rdy2), .mem_cmd_header_o(hdr2),
        .mem_cmd_header_v_o(v2), .mem_cmd_header_ready_and_i(net_rdy),
        .mem_credit_return_i(ret), .mem_credits_empty_o(empty2),
        .mem_credits_full_o(full2), .mem_credit_count_o(cnt2),
        .credit_error_o(err2)
    );

    function automatic int maxc(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mcr[k]  = maxc(k);
            merr[k] = 1'b0;
        end
    endtask

    // Gate behaviour: accept when room and credit, send when non-empty and network ready.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit can_take = (mq[k].size() < 2) && (mcr[k] != 0);
            bit acc      = v_in && can_take;
            bit snd      = (mq[k].size() != 0) && net_rdy;
            if (snd) void'(mq[k].pop_front());
            if (acc) mq[k].push_back(hdr);
            if (acc && !ret) mcr[k] = mcr[k] - 1;
            else if (!acc && ret) begin
                if (mcr[k] == maxc(k)) merr[k] = 1'b1;
                else mcr[k] = mcr[k] + 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic          a_v   = k ? v2 : v8;
            logic [HW-1:0] a_h   = k ? hdr2 : hdr8;
            logic          a_r   = k ? rdy2 : rdy8;
            int            a_c   = k ? int'(cnt2) : int'(cnt8);
            logic          a_e   = k ? empty2 : empty8;
            logic          a_f   = k ? full2 : full8;
            logic          a_err = k ? err2 : err8;
            check($sformatf("v_o[%0d]", k), 32'(a_v), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0) check($sformatf("header_o[%0d]", k), 32'(a_h), 32'(mq[k][0]));
            check($sformatf("ready_and_o[%0d]", k), 32'(a_r), 32'((mq[k].size() < 2) && (mcr[k] != 0)));
            check($sformatf("count[%0d]", k), 32'(a_c), 32'(mcr[k]));
            check($sformatf("empty[%0d]", k), 32'(a_e), 32'(mcr[k] == 0));
            check($sformatf("full[%0d]", k), 32'(a_f), 32'(mcr[k] == maxc(k)));
            check($sformatf("error[%0d]", k), 32'(a_err), 32'(merr[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        hdr = '0; v_in = 1'b0; net_rdy = 1'b0; ret = 1'b0;
        model_reset();
        do_reset(3);
        check("reset count8", 32'(cnt8), 32'd8);
        check("reset full8", 32'(full8), 32'd1);
        check("reset v8", 32'(v8), 32'd0);
        check("reset ready8", 32'(rdy8), 32'd1);
        check("reset header8", 32'(hdr8), 32'd0);
        check("reset empty8", 32'(empty8), 32'd0);
        check("reset error8", 32'(err8), 32'd0);

        // Credit exhaustion on the 2-credit gate, back-to-back with network ready.
        net_rdy = 1'b1; v_in = 1'b1;
        hdr = 16'hA001; tick();
        hdr = 16'hA002; tick();
        check("exhaust ready2", 32'(rdy2), 32'd0);
        check("exhaust empty2", 32'(empty2), 32'd1);
        check("exhaust head2", 32'(hdr2), 32'hA002);
        hdr = 16'hA003; tick();
        check("exhaust count2", 32'(cnt2), 32'd0);
        check("pre-simul count8", 32'(cnt8), 32'd5);
        ret = 1'b1; tick();
        check("simul count8", 32'(cnt8), 32'd5);
        check("returned count2", 32'(cnt2), 32'd1);
        ret = 1'b0; tick();
        check("third accepted v2", 32'(v2), 32'd1);
        check("third accepted head2", 32'(hdr2), 32'hA003);
        check("third accepted count2", 32'(cnt2), 32'd0);
        v_in = 1'b0; tick();
        do_reset(2);

        // Backpressure: network stalled, only two headers fit.
        net_rdy = 1'b0; v_in = 1'b1;
        hdr = 16'hB00A; tick();
        hdr = 16'hB00B; tick();
        hdr = 16'hB00C; tick(); tick();
        check("bp ready8", 32'(rdy8), 32'd0);
        check("bp v8", 32'(v8), 32'd1);
        check("bp head8", 32'(hdr8), 32'hB00A);
        check("bp count8", 32'(cnt8), 32'd6);
        net_rdy = 1'b1; tick();
        check("drain head8 B", 32'(hdr8), 32'hB00B);
        tick();
        check("drain head8 C", 32'(hdr8), 32'hB00C);
        check("drain count8", 32'(cnt8), 32'd5);
        v_in = 1'b0; tick();
        check("drained v8", 32'(v8), 32'd0);
        do_reset(2);

        // Overflow: return at max credits sets a sticky error.
        ret = 1'b1; tick();
        ret = 1'b0;
        check("overflow error8", 32'(err8), 32'd1);
        check("overflow count8", 32'(cnt8), 32'd8);
        repeat (10) tick();
        check("sticky error8", 32'(err8), 32'd1);
        check("sticky error2", 32'(err2), 32'd1);
        check("sticky count8", 32'(cnt8), 32'd8);
        do_reset(2);

        // Mid-operation asynchronous reset at occupancy 2, count 3.
        net_rdy = 1'b1; v_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hdr = 16'(16'hD000 + i);
            tick();
        end
        net_rdy = 1'b0; hdr = 16'hD004; tick();
        v_in = 1'b0;
        check("pre-reset count8", 32'(cnt8), 32'd3);
        check("pre-reset ready8", 32'(rdy8), 32'd0);
        check("pre-reset head8", 32'(hdr8), 32'hD003);
        #2 rst_n = 1'b0;
        #1;
        check("async v8", 32'(v8), 32'd0);
        check("async count8", 32'(cnt8), 32'd8);
        check("async full8", 32'(full8), 32'd1);
        check("async ready8", 32'(rdy8), 32'd1);
        check("async v2", 32'(v2), 32'd0);
        check("async count2", 32'(cnt2), 32'd2);
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/bp_cce_mem_cmd_gate.md
# bp_cce_mem_cmd_gate

Output-side gate for the CCE memory command path. It accepts memory command headers from the CCE under a ready-and handshake and holds them in a two-entry buffer until the memory network takes them. It also tracks memory credits, taking one per accepted command and returning one per memory response consumed. It produces the `mem_cmd_header_ready_and` and `mem_credits_empty` signals that the CCE instruction stall logic consumes, and sits between the CCE message unit and the memory command network port.

## Interface
Parameters:
- `mem_noc_max_credits_p`, default 8: maximum outstanding memory commands. Must be ≥ 1.
- `header_width_p`, default 128: memory command header width in bits, treated as opaque payload.
- `lg_credits_lp`, derived as `$clog2(mem_noc_max_credits_p+1)`: credit counter width.

Ports:
- `clk_i` input 1: single clock. All state is on the rising edge.
- `reset_n_i` input 1: reset, asynchronous and active-low.
- `mem_cmd_header_i` input `header_width_p`: header from the CCE.
- `mem_cmd_header_v_i` input 1: CCE header valid.
- `mem_cmd_header_ready_and_o` output 1: gate can accept a header. Acceptance is `v_i & ready_and_o`.
- `mem_cmd_header_o` output `header_width_p`: head-of-buffer header to the network.
- `mem_cmd_header_v_o` output 1: buffer non-empty.
- `mem_cmd_header_ready_and_i` input 1: network ready. A send occurs on `v_o & ready_and_i`.
- `mem_credit_return_i` input 1: one-cycle pulse per consumed memory response header.
- `mem_credits_empty_o` output 1: credit count is 0.
- `mem_credits_full_o` output 1: credit count equals `mem_noc_max_credits_p`.
- `mem_credit_count_o` output `lg_credits_lp`: current credit count.
- `credit_error_o` output 1: sticky flag for a credit return while the count is at maximum.

## Operation
- Credit counter:
  - Resets to `mem_noc_max_credits_p`.
  - Accept without return: count −1.
  - Return without accept: count +1.
  - Accept and return in the same cycle: count unchanged.
  - Return while full and no accept in that cycle: count holds at max and `credit_error_o` sets. It stays set until reset.
- Underflow cannot occur, because `ready_and_o` is low when the count is 0.
- Buffer:
  - Two entries: head and tail registers, plus a 2-bit occupancy (0, 1 or 2).
  - Enqueue on accept; dequeue on send.
  - Simultaneous enqueue and dequeue at occupancy 1: the new header moves into head and occupancy stays 1.
  - Simultaneous enqueue and dequeue at occupancy 2: tail shifts to head, the new header goes into tail, and occupancy stays 2.
  - Order is strictly FIFO.
- `mem_cmd_header_ready_and_o = (occupancy != 2) & (count != 0)`. It is computed from registered state only, with no combinational path from `v_i` or `ready_and_i`.
- `mem_cmd_header_v_o = (occupancy != 0)`.
- `mem_cmd_header_o` is driven from the head register.
- Holding `v_i` high while `ready_and_o` is low has no effect.
- Reset mid-operation clears the buffer and restores full credits; in-flight headers are dropped.

## Timing
- Reset values:
  - `mem_cmd_header_v_o` = 0
  - `mem_cmd_header_ready_and_o` = 1
  - `mem_credits_empty_o` = 0
  - `mem_credits_full_o` = 1
  - `mem_credit_count_o` = `mem_noc_max_credits_p`
  - `credit_error_o` = 0
  - `mem_cmd_header_o` = 0
- Latency: a header accepted in cycle N is visible on `v_o` and `header_o` in N+1.
- Credit effects of an accept or return in cycle N appear on the count and flag outputs in N+1.
- Throughput: one header per cycle when the network is ready every cycle and credits are available.
- Once asserted, `v_o` and `header_o` stay stable until a send occurs.

## Structure
- Sub-module `bp_cce_mem_cmd_buffer`: the two-entry ready-and/valid header buffer, with occupancy and simultaneous enqueue/dequeue handling.
- The top level holds the credit counter, the error flag and the ready-and gating.
- No new typedefs. The credit width is derived locally.
- The default header width matches the `bp_common` memory header size. Any header struct casting is done by the instantiating CCE, not inside this block.

## Test plan
- **Reset:** hold `reset_n_i` low for 3 cycles, release → count = 8, `full_o` = 1, `v_o` = 0, `ready_and_o` = 1.
- **Credit exhaustion:** max = 2, network ready, send 3 headers back-to-back →
  - headers 1–2 accepted;
  - `ready_and_o` = 0 and `empty_o` = 1 in the cycle after the second accept;
  - the third header is accepted one cycle after a `mem_credit_return_i` pulse.
- **Backpressure:** network `ready_and_i` = 0 with 8 credits → exactly 2 headers accepted (A, B), then `ready_and_o` = 0. Raise `ready_and_i` → A then B emerge in consecutive cycles.
- **Simultaneous events:** at count 5, assert an accept and a return together → count stays 5. At occupancy 2, enqueue C while dequeuing A → head = B, tail = C.
- **Overflow error:** at count = max, pulse return → count stays at max and `credit_error_o` = 1, still 1 after 10 idle cycles.
- **Mid-operation reset:** occupancy 2, count 3, assert `reset_n_i` low asynchronously → `v_o` = 0 and count = max immediately, without waiting for a clock edge.
